// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory arbiter slice.
//   - CMD_* : 8-bit memory command encodings driven on mem_cmd
//   - state_t : arbiter FSM states
//   - PORT_CPU / PORT_LDR : requester indices (also the encoding of last_grant)
package dmem_pkg;

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the memory bus of dmem_arbiter.
//   Ports (signals):
//     req0/1, we0/1, addr0/1, wdata0/1 : requester transaction fields
//     gnt0/1, rvalid0/1, rdata, busy   : arbiter responses
//     mem_cmd, mem_addr, mem_wdata     : memory command bus
//     mem_rdata                        : memory read data
//   Modports:
//     master : the environment (requesters + memory) driving requests and read data
//     slave  : the arbiter serving them
interface dmem_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;

  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;

  logic [7:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
    input  mem_cmd, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
    output mem_cmd, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way winner select.
//   Ports:
//     req0, req1 : in  request lines of port 0 / port 1
//     last_grant : in  port that won the previous arbitration
//     grant      : out selected port (PORT_CPU / PORT_LDR), only meaningful when valid
//     valid      : out at least one port is requesting
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int CPU_PRIORITY = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  // A lone requester always wins. On a tie either port 0 wins outright
  // (fixed priority) or the port that did not win last time does.
  always_comb begin
    grant = PORT_CPU;
    if (req0 && req1) begin
      if (CPU_PRIORITY != 0) begin
        grant = PORT_CPU;
      end else begin
        grant = ~last_grant;
      end
    end else if (req1) begin
      grant = PORT_LDR;
    end
  end

  assign valid = req0 | req1;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the CPU (port 0) and the
//   loader/debug port (port 1). One transaction at a time: IDLE picks a
//   winner, ISSUE drives the command for one cycle with the grant pulse,
//   WAIT_RD counts out the memory read latency and returns the data with a
//   one-cycle rvalid pulse on the owning port. All outputs are registered.
//   Ports:
//     clk   : in  system clock, rising edge
//     rst_n : in  synchronous active-low reset
//     bus   : dmem_arbiter_if.slave (requesters, responses, memory bus)
//   Parameters:
//     DW, AW       : data / address width
//     MEM_RD_LAT   : cycles from READ command to valid mem_rdata (1..7)
//     CPU_PRIORITY : 1 = port 0 wins ties, 0 = round-robin
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW           = 8,
  parameter int AW           = 8,
  parameter int MEM_RD_LAT   = 1,
  parameter int CPU_PRIORITY = 0
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  if (MEM_RD_LAT < 1 || MEM_RD_LAT > 7) begin : g_bad_rd_lat
    $error("dmem_arbiter: MEM_RD_LAT must be in the range 1..7");
  end

  state_t        state;
  logic          last_grant;
  logic          cur_we;
  logic [2:0]    wait_cnt;

  logic          winner;
  logic          any_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 #(
    .CPU_PRIORITY(CPU_PRIORITY)
  ) u_arb (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_grant(last_grant),
    .grant     (winner),
    .valid     (any_req)
  );

  // Transaction fields of whichever port the arbiter currently favours.
  assign sel_we    = (winner == PORT_LDR) ? bus.we1    : bus.we0;
  assign sel_addr  = (winner == PORT_LDR) ? bus.addr1  : bus.addr0;
  assign sel_wdata = (winner == PORT_LDR) ? bus.wdata1 : bus.wdata0;

  // Main FSM. Grant and rvalid default low every cycle so they pulse for
  // exactly one cycle. last_grant doubles as the owner of an outstanding
  // read, since no new arbitration happens until the read has returned.
  // mem_addr/mem_wdata/rdata are only written when a new value is meant to
  // appear, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= PORT_LDR;
      cur_we        <= 1'b0;
      wait_cnt      <= 3'd0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.rvalid0   <= 1'b0;
      bus.rvalid1   <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_cmd   <= CMD_IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state         <= ST_ISSUE;
            bus.busy      <= 1'b1;
            last_grant    <= winner;
            cur_we        <= sel_we;
            bus.mem_cmd   <= sel_we ? CMD_WRITE : CMD_READ;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.gnt0      <= (winner == PORT_CPU);
            bus.gnt1      <= (winner == PORT_LDR);
          end
        end
        ST_ISSUE: begin
          bus.mem_cmd <= CMD_IDLE;
          if (cur_we) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else begin
            state    <= ST_WAIT_RD;
            wait_cnt <= 3'(MEM_RD_LAT);
          end
        end
        ST_WAIT_RD: begin
          // The count reaching 1 marks the edge at which mem_rdata is valid.
          if (wait_cnt == 3'd1) begin
            state       <= ST_IDLE;
            bus.busy    <= 1'b0;
            bus.rdata   <= bus.mem_rdata;
            bus.rvalid0 <= (last_grant == PORT_CPU);
            bus.rvalid1 <= (last_grant == PORT_LDR);
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          bus.busy    <= 1'b0;
          bus.mem_cmd <= CMD_IDLE;
        end
      endcase
    end
  end

endmodule
